// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, types and helpers for the write-back
// register file and its pending-write scoreboard.
package regfile_pkg;

  localparam int XLEN      = 64;
  localparam int REG_NUM   = 32;
  localparam int REGADDR_W = 5;
  localparam int PEND_W    = 2;
  localparam int RETIRE_W  = 64;

  typedef logic [PEND_W-1:0]    pend_t;
  typedef logic [XLEN-1:0]      xdata_t;
  typedef logic [REGADDR_W-1:0] regaddr_t;

  // A source read is a hazard when the register has writes in flight,
  // unless the only outstanding write is being forwarded this very cycle.
  function automatic logic src_hazard(input logic     ena,
                                      input regaddr_t addr,
                                      input logic     zero,
                                      input pend_t    cnt,
                                      input logic     wb_hit);
    logic hz;
    hz = 1'b0;
    if (ena && (addr != 5'd0) && !zero) begin
      if (wb_hit && (cnt == pend_t'(1'b1))) begin
        hz = 1'b0;
      end else begin
        hz = 1'b1;
      end
    end else begin
      hz = 1'b0;
    end
    return hz;
  endfunction

endpackage

// File: rtl/regfile_wb_sb_counter.sv
// sb_counter: saturating up/down counter tracking in-flight writes to one
// register. Simultaneous inc and dec cancel; clr has priority over both.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int W = PEND_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         zero
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;

  assign full = (cnt_r == {W{1'b1}});
  assign zero = (cnt_r == {W{1'b0}});
  assign cnt  = cnt_r;

  // Next count: clear, saturating increment/decrement, or hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = {W{1'b0}};
    end else if (inc && !dec) begin
      if (!full) begin
        cnt_nxt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (dec && !inc) begin
      if (!zero) begin
        cnt_nxt_s = cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: integer register file fed by write-back, with two read ports,
// a per-register pending-write scoreboard driving raw_stall, and a retire
// counter. Optional same-cycle write-back forwarding: REGFILE_BYPASS_EN.
module regfile_wb
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_rd_ena,
  input  logic [REGADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]      wb_rd_data,
  input  logic                 wb_valid,
  input  logic                 rs1_ena,
  input  logic [REGADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]      rs1_data,
  input  logic                 rs2_ena,
  input  logic [REGADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]      rs2_data,
  input  logic                 issue_ena,
  input  logic [REGADDR_W-1:0] issue_rd_addr,
  input  logic                 flush,
  output logic                 raw_stall,
  output logic [RETIRE_W-1:0]  retire_cnt
);

  xdata_t                regs_r [REG_NUM];
  pend_t                 pend_s [REG_NUM];
  logic                  full_s [REG_NUM];
  logic                  zero_s [REG_NUM];
  logic [REG_NUM-1:0]    inc_s;
  logic [REG_NUM-1:0]    dec_s;
  logic                  rs1_fwd_s;
  logic                  rs2_fwd_s;
  logic [RETIRE_W-1:0]   retire_cnt_r;

  // x0 has no scoreboard entry: never pending, never full.
  assign pend_s[0] = pend_t'(1'b0);
  assign full_s[0] = 1'b0;
  assign zero_s[0] = 1'b1;

`ifdef REGFILE_BYPASS_EN
  assign rs1_fwd_s = wb_rd_ena && (wb_rd_addr == rs1_addr) && (rs1_addr != 5'd0);
  assign rs2_fwd_s = wb_rd_ena && (wb_rd_addr == rs2_addr) && (rs2_addr != 5'd0);
`else
  assign rs1_fwd_s = 1'b0;
  assign rs2_fwd_s = 1'b0;
`endif

  // Decode scoreboard increments (issue, dropped on flush) and decrements (write-back).
  always_comb begin
    inc_s = {REG_NUM{1'b0}};
    dec_s = {REG_NUM{1'b0}};
    for (int r = 1; r < REG_NUM; r++) begin
      if (issue_ena && !flush && (issue_rd_addr == REGADDR_W'(r))) begin
        inc_s[r] = 1'b1;
      end else begin
        inc_s[r] = 1'b0;
      end
      if (wb_rd_ena && (wb_rd_addr == REGADDR_W'(r))) begin
        dec_s[r] = 1'b1;
      end else begin
        dec_s[r] = 1'b0;
      end
    end
  end

  for (genvar g = 1; g < REG_NUM; g++) begin : g_sb
    sb_counter #(.W(PEND_W)) u_sb (
      .clk  (clk),
      .rst  (rst),
      .clr  (flush),
      .inc  (inc_s[g]),
      .dec  (dec_s[g]),
      .cnt  (pend_s[g]),
      .full (full_s[g]),
      .zero (zero_s[g])
    );
  end

  // Register storage: write-back writes any register except x0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else if (wb_rd_ena && (wb_rd_addr != 5'd0)) begin
      regs_r[wb_rd_addr] <= wb_rd_data;
    end else begin
      regs_r[0] <= {XLEN{1'b0}};
    end
  end

  // Read port 1: zero for x0 or idle port, forwarded data when bypassing.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (!rs1_ena || (rs1_addr == 5'd0)) begin
      rs1_data = {XLEN{1'b0}};
    end else if (rs1_fwd_s) begin
      rs1_data = wb_rd_data;
    end else begin
      rs1_data = regs_r[rs1_addr];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (!rs2_ena || (rs2_addr == 5'd0)) begin
      rs2_data = {XLEN{1'b0}};
    end else if (rs2_fwd_s) begin
      rs2_data = wb_rd_data;
    end else begin
      rs2_data = regs_r[rs2_addr];
    end
  end

  // Stall when a source is still pending or the issuing rd counter is saturated.
  always_comb begin
    raw_stall = 1'b0;
    if (src_hazard(rs1_ena, rs1_addr, zero_s[rs1_addr], pend_s[rs1_addr], rs1_fwd_s) ||
        src_hazard(rs2_ena, rs2_addr, zero_s[rs2_addr], pend_s[rs2_addr], rs2_fwd_s) ||
        (issue_ena && full_s[issue_rd_addr])) begin
      raw_stall = 1'b1;
    end else begin
      raw_stall = 1'b0;
    end
  end

  // Retire counter: one per retiring instruction, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_r <= {RETIRE_W{1'b0}};
    end else if (wb_valid) begin
      retire_cnt_r <= retire_cnt_r + 64'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign retire_cnt = retire_cnt_r;

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Integer register file on the receiving end of the write-back interface, with a pending-write scoreboard and a retire counter. It accepts the write-back stage's rd write (enable, address, data) and serves two decode-stage read ports. Per-register in-flight write counters drive a RAW hazard stall back to decode. It sits between the write-back pipeline register and the decode/issue logic.

## Interface
- XLEN, 64, register and data width
- PEND_W, 2, width of each per-register pending-write counter (max in-flight = 2^PEND_W − 1)

- clk  in  1  core clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- wb_rd_ena  in  1  write-back write enable
- wb_rd_addr  in  5  write-back destination register
- wb_rd_data  in  XLEN  write-back data
- wb_valid  in  1  one instruction retires this cycle (non-bubble in WB)
- rs1_ena / rs2_ena  in  1  source read requests from decode
- rs1_addr / rs2_addr  in  5  source register addresses
- rs1_data / rs2_data  out  XLEN  read data, combinational
- issue_ena  in  1  decode issues an instruction that writes rd this cycle
- issue_rd_addr  in  5  rd of the issuing instruction
- flush  in  1  pipeline flush; clears scoreboard
- raw_stall  out  1  decode must hold: source pending or scoreboard full
- retire_cnt  out  64  count of retired instructions

## Operation
- Storage: x1..x31, XLEN bits each. x0 reads 0 and ignores writes.
- Write: at posedge, if wb_rd_ena and wb_rd_addr != 0, reg[wb_rd_addr] <= wb_rd_data.
- Read: rsN_data = 0 if rsN_addr == 0 or rsN_ena == 0, else reg[rsN_addr]. Bypass is covered under Configuration.
- Scoreboard: pend[r], PEND_W bits, r = 1..31. Per posedge:
  - flush: all pend <= 0. Issue in the same cycle is dropped. Write-back still writes data.
  - else issue only (issue_ena, addr r != 0): pend[r] + 1.
  - else write-back only (wb_rd_ena, addr r != 0): pend[r] − 1, saturating at 0. Post-flush write-backs land on 0.
  - else issue and write-back to the same r in the same cycle: pend[r] unchanged.
  - Issue or write-back to x0: no scoreboard effect.
- raw_stall = any of:
  - rsN_ena && rsN_addr != 0 && pend[rsN_addr] != 0, excluding the bypass case;
  - issue_ena && pend[issue_rd_addr] == max. An issue while full is ignored by the scoreboard.
- retire_cnt: +1 at posedge when wb_valid; wraps at 2^64 to 0.

## Timing
- Reset (rst = 0, async):
  - all registers 0, all pend 0, retire_cnt 0;
  - therefore rs1_data = rs2_data = 0 and raw_stall = 0 while in reset.
- Write-to-read latency: 1 cycle without bypass; 0 cycles with bypass.
- Scoreboard update visible to raw_stall the cycle after issue or write-back.
- raw_stall is purely combinational from pend and current inputs; no registered output.
- Reset asserted mid-operation discards all pending counts and register contents immediately.

## Configuration
- REGFILE_BYPASS_EN defined:
  - if wb_rd_ena && wb_rd_addr == rsN_addr != 0, rsN_data = wb_rd_data in the same cycle;
  - raw_stall ignores rsN when pend[rsN_addr] == 1 and that write-back is occurring.
- Undefined:
  - no forwarding; the read sees the old value;
  - raw_stall asserts through the write-back cycle and releases the next cycle.

## Structure
- Shared package regfile_pkg holds: XLEN, REG_NUM = 32, REGADDR_W = 5, PEND_W default, pend_t typedef.
- One sub-module, sb_counter: a saturating up/down counter with inc, dec, clr, and full/zero flags.
  - Instantiated 31 times, generate-indexed by register.

## Test plan
- Reset mid-run after writing x5 = 0x1234 → x5 reads 0, raw_stall 0, retire_cnt 0.
- Write x0 = 0xFFFF, read rs1 = x0 → rs1_data 0; pend untouched.
- Issue x7, write-back x7 = 0xABCD 3 cycles later, rs1 = x7 requested every cycle:
  - raw_stall = 1 until write-back;
  - with REGFILE_BYPASS_EN, data 0xABCD and stall 0 in the write-back cycle;
  - without it, stall 1 then data 0xABCD on the next cycle.
- Issue x3 three times → pend 3; a 4th issue raises raw_stall, pend stays 3. Simultaneous issue and write-back of x3 → pend stays 3.
- Issue x9 twice, flush, then write-back x9 → pend 0 and never underflows; data written; rs x9 not stalled.
- 10 cycles of wb_valid = 1, including 2 with wb_rd_ena = 0 → retire_cnt = 10.
